// File: rtl/fifo_burst_writer.sv
// -----------------------------------------------------------------------------
// fifo_burst_writer
//
// Write-side burst controller for a dual-clock FIFO, running on the FIFO write
// clock. It accepts a valid/ready word stream and pushes it into the FIFO in
// whole bursts of BURST_LEN words. A burst is started only when the FIFO
// reports half_empty, which guarantees room for the full burst. After the
// requested number of bursts it pulses done for one cycle.
//
// Optional feature: define FIFO_BURST_WRITER_PAD_EN to enable padding. When it
// is defined, an abort in the middle of a burst completes that burst with
// PAD_VALUE words, so the reader only ever sees whole bursts.
//
// Ports
//   wclk            in   write clock, positive edge
//   rst             in   asynchronous reset, active high
//   start           in   one-cycle transfer request, honoured only when idle
//   nbursts         in   number of bursts, sampled together with start
//   abort           in   terminate the transfer (level)
//   s_valid         in   upstream word valid
//   s_data          in   upstream word
//   s_ready         out  word accepted this cycle when s_valid is also high
//   fifo_half_empty in   FIFO half_empty flag (wclk domain)
//   fifo_we         out  FIFO write enable (one cycle after the transfer)
//   fifo_din        out  FIFO write data
//   busy            out  high whenever a transfer is in progress
//   done            out  one-cycle pulse at the end of a transfer
//   bursts_left     out  bursts remaining, including the current one
// -----------------------------------------------------------------------------
module fifo_burst_writer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    BURST_LEN  = 6,
    parameter int                    NB_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NB_WIDTH-1:0]   nbursts,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  fifo_half_empty,
    output logic                  fifo_we,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  busy,
    output logic                  done,
    output logic [NB_WIDTH-1:0]   bursts_left
);

    localparam int MAX_BURST = 3 * (1 << FIFO_DEPTH) / 8;
    localparam int WC_W      = $clog2(BURST_LEN + 1);
    localparam logic [WC_W-1:0] BURST_FIRST = WC_W'(BURST_LEN - 1);

    // A burst must fit in the space half_empty guarantees (3/8 of the depth).
    generate
        if (FIFO_DEPTH < 3 || BURST_LEN < 1 || BURST_LEN > MAX_BURST) begin : g_bad_cfg
            $error("fifo_burst_writer: BURST_LEN exceeds guaranteed FIFO room");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef FIFO_BURST_WRITER_PAD_EN
    localparam logic [2:0] S_PAD   = 3'd4;
`endif

    logic [2:0]            state_q, state_d;
    logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
    logic [NB_WIDTH-1:0]   bursts_left_q, bursts_left_d;
    logic                  fifo_we_q;
    logic [DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
    logic                  xfer;
    logic                  pad_write;

    assign s_ready = (state_q == S_BURST) && !abort;
    assign xfer    = s_valid && s_ready;

`ifdef FIFO_BURST_WRITER_PAD_EN
    assign pad_write = (state_q == S_PAD);
`else
    assign pad_write = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        bursts_left_d = bursts_left_q;
        fifo_din_d    = fifo_din_q;

        if (pad_write) begin
            fifo_din_d = PAD_VALUE;
        end else if (xfer) begin
            fifo_din_d = s_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (nbursts != '0) begin
                        bursts_left_d = nbursts;
                        state_d       = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d       = S_IDLE;
                    bursts_left_d = '0;
                end else if (!fifo_we_q && fifo_half_empty) begin
                    // The flag is only trusted once the previous burst's last
                    // write has left the output register.
                    word_cnt_d = BURST_FIRST;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                if (abort) begin
`ifdef FIFO_BURST_WRITER_PAD_EN
                    if (word_cnt_q != BURST_FIRST) begin
                        // Part of the burst is already in the FIFO: finish it.
                        state_d = S_PAD;
                    end else begin
                        state_d       = S_IDLE;
                        bursts_left_d = '0;
                    end
`else
                    state_d       = S_IDLE;
                    bursts_left_d = '0;
`endif
                end else if (s_valid) begin
                    if (word_cnt_q == '0) begin
                        if (bursts_left_q == NB_WIDTH'(1)) begin
                            // Last burst: hold at 1 while DONE is still busy.
                            state_d = S_DONE;
                        end else begin
                            bursts_left_d = bursts_left_q - NB_WIDTH'(1);
                            state_d       = S_WAIT;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q - WC_W'(1);
                    end
                end
            end
`ifdef FIFO_BURST_WRITER_PAD_EN
            S_PAD: begin
                if (word_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q - WC_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_d       = S_IDLE;
                bursts_left_d = '0;
            end
            default: begin
                state_d       = S_IDLE;
                bursts_left_d = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            bursts_left_q <= '0;
            fifo_we_q     <= 1'b0;
            fifo_din_q    <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            bursts_left_q <= bursts_left_d;
            fifo_we_q     <= xfer || pad_write;
            fifo_din_q    <= fifo_din_d;
        end
    end

    assign fifo_we     = fifo_we_q;
    assign fifo_din    = fifo_din_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign bursts_left = bursts_left_q;

endmodule
